// File: rtl/regfile_sb_if.sv
// Register file bus for regfile_sb: read ports, destination claim and write-back.
//
// Signalling: every request (rd_en, claim_en, we) is a single-cycle strobe that
// is sampled on the rising clock edge and always accepted; there is no ready or
// backpressure. The regfile reports back through registered outputs: rdata/rbusy
// update on the edge that samples rd_en, and pend_cnt/claim_err on the edge that
// applies a claim or write.
interface regfile_sb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
);
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic              rd_en;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rbusy1;
  logic              rbusy2;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  pend_cnt;
  logic              claim_err;

  // Control side (CPU datapath FSM)
  modport master (
    output rd_en, raddr1, raddr2, claim_en, claim_addr, we, waddr, wdata,
    input  rdata1, rdata2, rbusy1, rbusy2, pend_cnt, claim_err
  );

  // Register file side
  modport slave (
    input  rd_en, raddr1, raddr2, claim_en, claim_addr, we, waddr, wdata,
    output rdata1, rdata2, rbusy1, rbusy2, pend_cnt, claim_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two registered read ports and a per-register pending-write
// scoreboard. A claim marks a destination pending at issue; write-back clears it.
// Read ports return the captured source's pending flag so control can stall in ID.
//
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read and a write to
// the same valid, non-zero address on the same edge forward the write data (and a
// cleared busy, unless that edge also claims the address). When undefined, reads
// capture the pre-edge register value and pending bit.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_sb_if.slave    bus
);
  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;
  logic                claim_err_q, claim_err_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic                rbusy1_q, rbusy1_d, rbusy2_q, rbusy2_d;

  logic wr_ok, cl_ok, same_wc, cl_was_pend, wr_was_pend;

  // Addresses at or above NUM_REGS are out of range and never match a register.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < ADDR_LIMIT;
  endfunction

  // Mux a register value; out-of-range addresses read 0.
  function automatic logic [DATA_W-1:0] sel_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) v = regs_q[i];
    return v;
  endfunction

  // Mux a pending bit; out-of-range addresses are never pending.
  function automatic logic sel_pend(input logic [ADDR_W-1:0] a);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) v = pend_q[i];
    return v;
  endfunction

  // Qualify write and claim: range check, and register 0 is immutable when hardwired.
  always_comb begin
    wr_ok       = bus.we && in_range(bus.waddr) &&
                  !(ZERO_REG == 1 && bus.waddr == '0);
    cl_ok       = bus.claim_en && in_range(bus.claim_addr) &&
                  !(ZERO_REG == 1 && bus.claim_addr == '0);
    same_wc     = wr_ok && cl_ok && (bus.waddr == bus.claim_addr);
    cl_was_pend = sel_pend(bus.claim_addr);
    wr_was_pend = sel_pend(bus.waddr);
  end

  // Scoreboard next state: write clears, claim sets, so a same-address claim wins.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && bus.waddr == ADDR_W'(i))      pend_d[i] = 1'b0;
      if (cl_ok && bus.claim_addr == ADDR_W'(i)) pend_d[i] = 1'b1;
    end
    // Count tracks the popcount: +1 when a claim ends with a newly set bit,
    // -1 when a write clears a previously set bit.
    pend_cnt_d = pend_cnt_q
               + CNT_W'(cl_ok && (!cl_was_pend || same_wc))
               - CNT_W'(wr_ok && wr_was_pend);
    // Re-claiming a register that this edge does not release is a hazard error.
    claim_err_d = claim_err_q || (cl_ok && cl_was_pend && !same_wc);
  end

  // Read capture values, with optional same-edge write forwarding.
  always_comb begin
    rdata1_d = sel_data(bus.raddr1);
    rbusy1_d = sel_pend(bus.raddr1);
    rdata2_d = sel_data(bus.raddr2);
    rbusy2_d = sel_pend(bus.raddr2);
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && bus.raddr1 == bus.waddr && bus.raddr1 != '0) begin
      rdata1_d = bus.wdata;
      rbusy1_d = cl_ok && (bus.claim_addr == bus.raddr1);
    end
    if (wr_ok && bus.raddr2 == bus.waddr && bus.raddr2 != '0) begin
      rdata2_d = bus.wdata;
      rbusy2_d = cl_ok && (bus.claim_addr == bus.raddr2);
    end
`endif
  end

  // Register array write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (bus.waddr == ADDR_W'(i)) regs_q[i] <= bus.wdata;
    end
  end

  // Scoreboard, counter, sticky error and read-port capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      pend_cnt_q  <= '0;
      claim_err_q <= 1'b0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      rbusy1_q    <= 1'b0;
      rbusy2_q    <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      claim_err_q <= claim_err_d;
      if (bus.rd_en) begin
        rdata1_q <= rdata1_d;
        rdata2_q <= rdata2_d;
        rbusy1_q <= rbusy1_d;
        rbusy2_q <= rbusy2_d;
      end
    end
  end

  assign bus.rdata1    = rdata1_q;
  assign bus.rdata2    = rdata2_q;
  assign bus.rbusy1    = rbusy1_q;
  assign bus.rbusy2    = rbusy2_q;
  assign bus.pend_cnt  = pend_cnt_q;
  assign bus.claim_err = claim_err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (NUM_REGS=24, ZERO_REG=1), expectations hand-computed.
module tb_regfile_sb;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 24;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_en = 0; bus.raddr1 = '0; bus.raddr2 = '0;
    bus.claim_en = 0; bus.claim_addr = '0;
    bus.we = 0; bus.waddr = '0; bus.wdata = '0;
  endtask

  task automatic rnd_inputs();
    bus.rd_en      = 1'($urandom_range(0, 1));
    bus.raddr1     = ADDR_W'($urandom_range(0, 31));
    bus.raddr2     = ADDR_W'($urandom_range(0, 31));
    bus.claim_en   = 1'($urandom_range(0, 1));
    bus.claim_addr = ADDR_W'($urandom_range(0, 31));
    bus.we         = 1'($urandom_range(0, 1));
    bus.waddr      = ADDR_W'($urandom_range(0, 31));
    bus.wdata      = $urandom;
  endtask

  initial begin
    // Reset with random inputs for two cycles
    rst = 1'b0;
    rnd_inputs();
    step();
    rnd_inputs();
    step();
    check("rst_rdata1", bus.rdata1, 32'h0);
    check("rst_rdata2", bus.rdata2, 32'h0);
    check("rst_rbusy1", 32'(bus.rbusy1), 32'h0);
    check("rst_rbusy2", 32'(bus.rbusy2), 32'h0);
    check("rst_pend_cnt", 32'(bus.pend_cnt), 32'h0);
    check("rst_claim_err", 32'(bus.claim_err), 32'h0);

    // Release and read register 7
    idle();
    rst = 1'b1;
    bus.rd_en = 1; bus.raddr1 = 5'd7; bus.raddr2 = 5'd7;
    step();
    check("post_rst_rdata1", bus.rdata1, 32'h0);
    check("post_rst_rbusy1", 32'(bus.rbusy1), 32'h0);

    // Write 5, then read 5 and 0
    idle();
    bus.we = 1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    step();
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd5; bus.raddr2 = 5'd0;
    step();
    check("wr5_rdata1", bus.rdata1, 32'hDEADBEEF);
    check("rd0_rdata2", bus.rdata2, 32'h0);

    // rd_en low holds captured data
    idle();
    bus.raddr1 = 5'd7;
    step();
    check("hold_rdata1", bus.rdata1, 32'hDEADBEEF);

    // Writing register 0 has no effect
    idle();
    bus.we = 1; bus.waddr = 5'd0; bus.wdata = 32'h1234;
    step();
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    step();
    check("zero_rdata1", bus.rdata1, 32'h0);
    check("zero_rdata2", bus.rdata2, 32'h0);

    // Claim 3, read busy on both ports, write back, read value
    idle();
    bus.claim_en = 1; bus.claim_addr = 5'd3;
    step();
    check("claim3_cnt", 32'(bus.pend_cnt), 32'd1);
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd3; bus.raddr2 = 5'd3;
    step();
    check("claim3_rbusy1", 32'(bus.rbusy1), 32'd1);
    check("claim3_rbusy2", 32'(bus.rbusy2), 32'd1);
    idle();
    bus.we = 1; bus.waddr = 5'd3; bus.wdata = 32'h55;
    step();
    check("wb3_cnt", 32'(bus.pend_cnt), 32'd0);
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd3;
    step();
    check("wb3_rdata1", bus.rdata1, 32'h55);
    check("wb3_rbusy1", 32'(bus.rbusy1), 32'd0);

    // Collision: claim and write 3 on the same edge while 3 is pending
    idle();
    bus.claim_en = 1; bus.claim_addr = 5'd3;
    step();
    idle();
    bus.claim_en = 1; bus.claim_addr = 5'd3;
    bus.we = 1; bus.waddr = 5'd3; bus.wdata = 32'hAA;
    step();
    check("coll_cnt", 32'(bus.pend_cnt), 32'd1);
    check("coll_claim_err", 32'(bus.claim_err), 32'd0);
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd3;
    step();
    check("coll_rdata1", bus.rdata1, 32'hAA);
    check("coll_rbusy1", 32'(bus.rbusy1), 32'd1);
    idle();
    bus.claim_en = 1; bus.claim_addr = 5'd3;
    step();
    check("reclaim_err", 32'(bus.claim_err), 32'd1);
    check("reclaim_cnt", 32'(bus.pend_cnt), 32'd1);
    idle();
    step();
    step();
    check("sticky_err", 32'(bus.claim_err), 32'd1);

    // Same-edge read and write of pending register 9 (old value 0x11)
    idle();
    bus.we = 1; bus.waddr = 5'd9; bus.wdata = 32'h11;
    step();
    idle();
    bus.claim_en = 1; bus.claim_addr = 5'd9;
    step();
    check("claim9_cnt", 32'(bus.pend_cnt), 32'd2);
    idle();
    bus.we = 1; bus.waddr = 5'd9; bus.wdata = 32'h77;
    bus.rd_en = 1; bus.raddr1 = 5'd9;
    step();
`ifdef REGFILE_BYPASS_EN
    check("byp_rdata1", bus.rdata1, 32'h77);
    check("byp_rbusy1", 32'(bus.rbusy1), 32'd0);
`else
    check("nobyp_rdata1", bus.rdata1, 32'h11);
    check("nobyp_rbusy1", 32'(bus.rbusy1), 32'd1);
`endif
    check("wb9_cnt", 32'(bus.pend_cnt), 32'd1);
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd9;
    step();
    check("rd9_rdata1", bus.rdata1, 32'h77);
    check("rd9_rbusy1", 32'(bus.rbusy1), 32'd0);

    // Out of range address 30
    idle();
    bus.claim_en = 1; bus.claim_addr = 5'd30;
    bus.we = 1; bus.waddr = 5'd30; bus.wdata = 32'hCAFE;
    step();
    check("oor_cnt", 32'(bus.pend_cnt), 32'd1);
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd30; bus.raddr2 = 5'd30;
    step();
    check("oor_rdata1", bus.rdata1, 32'h0);
    check("oor_rbusy1", 32'(bus.rbusy1), 32'd0);
    check("oor_rdata2", bus.rdata2, 32'h0);

    // Load read ports with a nonzero value, then reset asynchronously mid-cycle
    idle();
    bus.rd_en = 1; bus.raddr1 = 5'd5;
    step();
    check("pre_arst_rdata1", bus.rdata1, 32'hDEADBEEF);
    idle();
    bus.claim_en = 1; bus.claim_addr = 5'd4;
    #2;
    rst = 1'b0;
    #1;
    check("arst_rdata1", bus.rdata1, 32'h0);
    check("arst_cnt", 32'(bus.pend_cnt), 32'h0);
    check("arst_claim_err", 32'(bus.claim_err), 32'h0);
    step();
    idle();
    rst = 1'b1;
    bus.rd_en = 1; bus.raddr1 = 5'd3; bus.raddr2 = 5'd4;
    step();
    check("after_rst_rdata1", bus.rdata1, 32'h0);
    check("after_rst_rbusy1", 32'(bus.rbusy1), 32'h0);
    check("after_rst_rbusy2", 32'(bus.rbusy2), 32'h0);
    check("after_rst_cnt", 32'(bus.pend_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with registered read ports and a per-register pending-write scoreboard, for the multi-cycle CPU datapath. Operands are captured in the ID state. A destination register is claimed at issue, and write-back in the WB state releases the claim. Read ports report whether the captured source still has a write outstanding, so the control FSM can hold in ID instead of consuming a stale value.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, implemented registers; must satisfy 2 ≤ NUM_REGS ≤ 2^ADDR_W
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and claims
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rd_en  in  1  capture strobe (asserted by control in the ID state)
- raddr1, raddr2  in  ADDR_W  read addresses
- rdata1, rdata2  out  DATA_W  registered read data
- rbusy1, rbusy2  out  1  registered pending flag of the captured source
- claim_en  in  1  reserve claim_addr as the destination of an issued instruction
- claim_addr  in  ADDR_W  register to reserve
- we  in  1  write-back enable (asserted by control in the WB state)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- pend_cnt  out  $clog2(NUM_REGS+1)  number of registers currently pending
- claim_err  out  1  sticky error flag: a claim was made on an already-pending register

## Operation
- Storage: NUM_REGS × DATA_W flops plus NUM_REGS pending bits.
- An address ≥ NUM_REGS is out of range: it reads 0 with busy 0, and writes and claims to it are ignored.
- Write: on a rising edge with we=1 and a valid address, regs[waddr] ← wdata and pending[waddr] ← 0.
  - With ZERO_REG=1, address 0 is never written.
- Claim: on a rising edge with claim_en=1 and a valid address, pending[claim_addr] ← 1.
  - A claim to address 0 is ignored when ZERO_REG=1.
  - A claim to an already-pending register leaves pending at 1 and sets claim_err, which holds until reset.
- Read: on a rising edge with rd_en=1:
  - rdata_n ← regs[raddr_n]
  - rbusy_n ← pending[raddr_n]
  - With rd_en=0, rdata and rbusy hold their previous values.
- pend_cnt always equals the popcount of the pending bits. It is maintained incrementally:
  - +1 on a claim that sets a bit;
  - −1 on a write that clears a set bit;
  - net 0 when both happen in the same edge, or on a write to a non-pending register (no underflow).
- Simultaneous claim and write to the same address: the write data commits and pending ends at 1 (the new claim wins). pend_cnt is unchanged.

## Timing
- Reset (rst=0, asynchronous): all registers, pending bits, rdata1/2, rbusy1/2, pend_cnt and claim_err go to 0 immediately. Deasserting rst mid-operation resumes from that cleared state, and any claim or write presented in the reset cycle is lost.
- Read latency: 1 cycle. Values appear on the edge that samples rd_en.
- Write and claim take effect on the same edge. A read in a later cycle sees them.
- Same-edge read and write to the same address: behaviour is set by the bypass macro (see Configuration).
- Two read ports may use the same address. Each captures identically.

## Configuration
- REGFILE_BYPASS_EN defined: a same-edge read and write to the same valid, non-zero address forward the write.
  - rdata_n ← wdata.
  - rbusy_n ← 0, unless the same edge also claims that address, in which case rbusy_n ← 1.
- REGFILE_BYPASS_EN undefined: the read captures the pre-edge register value and pending bit. The control FSM then needs one extra ID cycle after WB.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0. Release rst, set rd_en=1, raddr1=7 -> rdata1=0, rbusy1=0.
- Write then read: we=1, waddr=5, wdata=0xDEADBEEF. Next cycle rd_en=1, raddr1=5, raddr2=0 -> rdata1=0xDEADBEEF, rdata2=0. Then write 0x1234 to address 0 -> address 0 still reads 0.
- Scoreboard: claim 3 -> pend_cnt=1. Read 3 -> rbusy1=1. Write 3 with 0x55 -> pend_cnt=0. Read 3 -> rdata1=0x55, rbusy1=0.
- Collision: with 3 pending, claim 3 and write 3 (0xAA) on the same edge -> pending[3]=1, pend_cnt=1, value 0xAA stored, claim_err=0. Claim 3 again -> claim_err=1, and it stays 1 until reset.
- Bypass: write 9 with 0x77 and read 9 on the same edge while 9 is pending.
  - With REGFILE_BYPASS_EN: rdata1=0x77, rbusy1=0.
  - Without it: old value returned, rbusy1=1.
- Out of range: NUM_REGS=24, claim 30 and write 30 -> pend_cnt unchanged, and a read of 30 returns 0 with busy 0.
